// File: rtl/boot_pkg.sv
// Shared types and constants for the boot block loader.
package boot_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FIN} boot_state_t;

    localparam int BLOCK_WORDS_LG = 5;
    localparam int LINE_WORDS_LG  = 3;
    localparam int DISK_ADDR_W    = 37;

endpackage

// File: rtl/boot_block_loader_line_packer.sv
// Collects 64-bit disk words into one memory line, indexed by word position.
module line_packer #(
    parameter int WORD_W     = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_clear,
    input  logic                           i_wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]  i_wr_idx,
    input  logic [WORD_W-1:0]              i_wr_data,
    output logic [WORD_W*LINE_WORDS-1:0]   o_line,
    output logic                           o_full
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [WORD_W*LINE_WORDS-1:0] r_line;
    logic                         r_full;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_line <= '0;
            r_full <= 1'b0;
        end else if (i_wr_en) begin
            r_line[i_wr_idx*WORD_W +: WORD_W] <= i_wr_data;
            r_full <= (i_wr_idx == IDX_W'(LINE_WORDS - 1));
        end
    end

    assign o_line = r_line;
    assign o_full = r_full;

endmodule

// File: rtl/boot_block_loader.sv
// Copies a run of disk blocks into main memory, one word request at a time,
// packing eight words per 512-bit line write.
module boot_block_loader
    import boot_pkg::*;
#(
    parameter int MEM_ADDR_W  = 26,
    parameter int BLOCK_WORDS = 32,
    parameter int LINE_WORDS  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 block_addr,
    input  logic [31:0]                 block_count,
    input  logic [MEM_ADDR_W-1:0]       mem_base,
    output logic                        disk_req_valid,
    input  logic                        disk_req_ready,
    output logic [DISK_ADDR_W-1:0]      disk_req_addr,
    input  logic                        disk_rsp_valid,
    input  logic [63:0]                 disk_rsp_data,
    output logic                        mem_wr_valid,
    input  logic                        mem_wr_ready,
    output logic [MEM_ADDR_W-1:0]       mem_wr_addr,
    output logic [64*LINE_WORDS-1:0]    mem_wr_data,
    output logic                        busy,
    output logic                        done
);
    localparam int WI_W = BLOCK_WORDS_LG;
    localparam int LI_W = LINE_WORDS_LG;

    boot_state_t              r_state;
    logic [31:0]              r_blk_ptr;
    logic [31:0]              r_blocks_left;
    logic [WI_W-1:0]          r_word_idx;
    logic [MEM_ADDR_W-1:0]    r_mem_base;
    logic [MEM_ADDR_W-1:0]    r_line_ctr;
    logic [MEM_ADDR_W-1:0]    r_mem_wr_addr;
    logic [DISK_ADDR_W-1:0]   r_disk_req_addr;
    logic                     r_disk_req_valid;
    logic                     r_mem_wr_valid;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_full;
    logic                     w_pk_clear;
    logic                     w_pk_wr;
    logic                     w_line_done;
    logic                     w_wr_accept;
    logic [WI_W-1:0]          w_next_idx;
    logic [64*LINE_WORDS-1:0] w_line;

    function automatic logic [DISK_ADDR_W-1:0] f_disk_addr(input logic [31:0] blk,
                                                           input logic [WI_W-1:0] idx);
        return DISK_ADDR_W'(blk) * DISK_ADDR_W'(BLOCK_WORDS) + DISK_ADDR_W'(idx);
    endfunction

    assign w_next_idx  = r_word_idx + WI_W'(1);
    assign w_line_done = (r_word_idx[LI_W-1:0] == LI_W'(LINE_WORDS - 1));
    assign w_wr_accept = (r_state == WRITE) && mem_wr_ready && w_full;
    assign w_pk_wr     = (r_state == WAIT) && disk_rsp_valid;
    // The line is emptied both at a new transfer and once memory has taken it.
    assign w_pk_clear  = ((r_state == IDLE) && start) || w_wr_accept;

    line_packer #(
        .WORD_W     (64),
        .LINE_WORDS (LINE_WORDS)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_pk_clear),
        .i_wr_en   (w_pk_wr),
        .i_wr_idx  (r_word_idx[LI_W-1:0]),
        .i_wr_data (disk_rsp_data),
        .o_line    (w_line),
        .o_full    (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_blk_ptr        <= '0;
            r_blocks_left    <= '0;
            r_word_idx       <= '0;
            r_mem_base       <= '0;
            r_line_ctr       <= '0;
            r_mem_wr_addr    <= '0;
            r_disk_req_addr  <= '0;
            r_disk_req_valid <= 1'b0;
            r_mem_wr_valid   <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_blk_ptr     <= block_addr;
                        r_blocks_left <= block_count;
                        r_mem_base    <= mem_base;
                        r_line_ctr    <= '0;
                        r_word_idx    <= '0;
                        if (block_count == 32'd0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state          <= REQ;
                            r_busy           <= 1'b1;
                            r_disk_req_valid <= 1'b1;
                            r_disk_req_addr  <= f_disk_addr(block_addr, '0);
                        end
                    end
                end
                REQ: begin
                    if (disk_req_ready) begin
                        r_disk_req_valid <= 1'b0;
                        r_state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (disk_rsp_valid) begin
                        r_word_idx <= w_next_idx;
                        if (w_line_done) begin
                            r_state        <= WRITE;
                            r_mem_wr_valid <= 1'b1;
                            r_mem_wr_addr  <= r_mem_base + r_line_ctr;
                        end else begin
                            r_state          <= REQ;
                            r_disk_req_valid <= 1'b1;
                            r_disk_req_addr  <= f_disk_addr(r_blk_ptr, w_next_idx);
                        end
                    end
                end
                WRITE: begin
                    if (w_wr_accept) begin
                        r_mem_wr_valid <= 1'b0;
                        r_line_ctr     <= r_line_ctr + MEM_ADDR_W'(1);
                        // word_idx has already wrapped when the last line of a block goes out
                        if (r_word_idx == '0) begin
                            r_blk_ptr     <= r_blk_ptr + 32'd1;
                            r_blocks_left <= r_blocks_left - 32'd1;
                            if (r_blocks_left == 32'd1) begin
                                r_state <= FIN;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state          <= REQ;
                                r_disk_req_valid <= 1'b1;
                                r_disk_req_addr  <= f_disk_addr(r_blk_ptr + 32'd1, '0);
                            end
                        end else begin
                            r_state          <= REQ;
                            r_disk_req_valid <= 1'b1;
                            r_disk_req_addr  <= f_disk_addr(r_blk_ptr, r_word_idx);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign disk_req_valid = r_disk_req_valid;
    assign disk_req_addr  = r_disk_req_addr;
    assign mem_wr_valid   = r_mem_wr_valid;
    assign mem_wr_addr    = r_mem_wr_addr;
    assign mem_wr_data    = w_line;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
